soc_system_hps_only_master_b2p: RTL and testbench

//  Avalon-ST bytes-to-packets decoder for the HPS-only master path. Consumes the raw 8-bit byte

---
 rtl/soc_system_hps_only_master_st_pkg.sv | 18 +
 rtl/soc_system_hps_only_master_b2p.sv | 110 +++++++++++
 tb/tb_soc_system_hps_only_master_b2p.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/soc_system_hps_only_master_st_pkg.sv
// Framing characters and decoder state shared by the bytes/packets converters.
package soc_system_hps_only_master_st_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  // Byte-stream decode state
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ESC      = 2'd1,
    CHAN     = 2'd2,
    CHAN_ESC = 2'd3
  } b2p_state_e;

endpackage

// File: rtl/soc_system_hps_only_master_b2p.sv
// Bytes-to-packets decoder: strips in-band framing and emits SOP/EOP/channel beats
// through a single registered output stage with backpressure.
module soc_system_hps_only_master_b2p
  import soc_system_hps_only_master_st_pkg::*;
#(
  parameter int unsigned CHANNEL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [CHANNEL_W-1:0] out_channel,
  input  logic                 out_ready
);

  b2p_state_e           state;
  logic                 sop_pend;
  logic                 eop_pend;
  logic [CHANNEL_W-1:0] chan_reg;

  logic                 accept;
  logic                 is_data;
  logic [7:0]           data_byte;
  logic [CHANNEL_W-1:0] chan_next;

  // Output slot is free when empty or being drained this cycle
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Classify the incoming byte and compute its decoded value
  always_comb begin
    is_data   = 1'b0;
    data_byte = in_data;
    chan_next = in_data[CHANNEL_W-1:0];
    unique case (state)
      NORMAL: begin
        is_data = (in_data != SOP_CHAR) && (in_data != EOP_CHAR) &&
                  (in_data != CHAN_CHAR) && (in_data != ESC_CHAR);
      end
      ESC: begin
        is_data   = 1'b1;
        data_byte = in_data ^ ESC_XOR;
      end
      CHAN_ESC: begin
        chan_next = in_data[CHANNEL_W-1:0] ^ ESC_XOR[CHANNEL_W-1:0];
      end
      default: ;
    endcase
  end

  // Decode FSM, pending markers, channel register and output beat register
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= NORMAL;
      sop_pend          <= 1'b0;
      eop_pend          <= 1'b0;
      chan_reg          <= '0;
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else begin
      if (in_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        unique case (state)
          NORMAL: begin
            if (in_data == SOP_CHAR)  sop_pend <= 1'b1;
            if (in_data == EOP_CHAR)  eop_pend <= 1'b1;
            if (in_data == CHAN_CHAR) state    <= CHAN;
            if (in_data == ESC_CHAR)  state    <= ESC;
          end
          ESC: begin
            state <= NORMAL;
          end
          CHAN: begin
            if (in_data == ESC_CHAR) begin
              state <= CHAN_ESC;
            end else begin
              chan_reg <= chan_next;
              state    <= NORMAL;
            end
          end
          CHAN_ESC: begin
            chan_reg <= chan_next;
            state    <= NORMAL;
          end
          default: state <= NORMAL;
        endcase
        if (is_data) begin
          out_valid         <= 1'b1;
          out_data          <= data_byte;
          out_startofpacket <= sop_pend;
          out_endofpacket   <= eop_pend;
          out_channel       <= chan_reg;
          sop_pend          <= 1'b0;
          eop_pend          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_system_hps_only_master_b2p.sv
// Bench for the bytes-to-packets decoder: two instances (8-bit and 4-bit channel)
// share one input stream and are compared against a byte-level reference decoder.
module tb_soc_system_hps_only_master_b2p;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready8, out_valid8, sop8, eop8;
  logic [7:0] out_data8, chan8;
  logic       in_ready4, out_valid4, sop4, eop4;
  logic [7:0] out_data4;
  logic [3:0] chan4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] chan;
    logic [7:0] data;
  } beat_t;

  // reference decoder state
  logic       m_esc, m_chan_wait, m_sop, m_eop;
  logic [7:0] m_chan;
  logic       exp_valid;
  beat_t      exp_q[$];

  always #5 clk = ~clk;

  soc_system_hps_only_master_b2p #(.CHANNEL_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_startofpacket(sop8),
    .out_endofpacket(eop8), .out_channel(chan8), .out_ready(out_ready));

  soc_system_hps_only_master_b2p #(.CHANNEL_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_startofpacket(sop4),
    .out_endofpacket(eop4), .out_channel(chan4), .out_ready(out_ready));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_esc = 1'b0; m_chan_wait = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_chan = 8'h00;
    exp_valid = 1'b0;
    exp_q.delete();
  endtask

  // Apply one accepted byte to the reference decoder
  task automatic model_byte(input logic [7:0] b, output logic prod, output beat_t bt);
    logic [7:0] v;
    prod = 1'b0;
    bt   = '0;
    v    = m_esc ? (b ^ 8'h20) : b;
    if (m_chan_wait) begin
      if (!m_esc && b == 8'h7D) begin
        m_esc = 1'b1;
      end else begin
        m_chan = v; m_esc = 1'b0; m_chan_wait = 1'b0;
      end
    end else if (!m_esc && b == 8'h7A) m_sop = 1'b1;
    else if (!m_esc && b == 8'h7B) m_eop = 1'b1;
    else if (!m_esc && b == 8'h7C) m_chan_wait = 1'b1;
    else if (!m_esc && b == 8'h7D) m_esc = 1'b1;
    else begin
      prod = 1'b1;
      bt   = '{sop: m_sop, eop: m_eop, chan: m_chan, data: v};
      m_sop = 1'b0; m_eop = 1'b0; m_esc = 1'b0;
    end
  endtask

  // Drive a byte list; valid/ready are random with given percentages, ready forced low
  // for the first 'stall' cycles of the run.
  task automatic run(input logic [7:0] bytes[$], input int vpct, input int rpct, input int stall);
    int    idx = 0;
    int    cyc = 0;
    int    budget = 30 * bytes.size() + 60;
    logic  prod;
    beat_t bt;
    while ((idx < bytes.size() || exp_valid) && cyc < budget) begin
      @(negedge clk);
      if (exp_valid) begin
        bt = exp_q[0];
        check("beat8", 32'({out_valid8, sop8, eop8, chan8, out_data8}),
                       32'({1'b1, bt.sop, bt.eop, bt.chan, bt.data}));
        check("beat4", 32'({out_valid4, sop4, eop4, chan4, out_data4}),
                       32'({1'b1, bt.sop, bt.eop, bt.chan[3:0], bt.data}));
      end else begin
        check("idle", 32'({out_valid8, out_valid4}), 32'd0);
      end
      out_ready = (cyc >= stall) && ($urandom_range(99) < 32'(rpct));
      if (idx < bytes.size() && $urandom_range(99) < 32'(vpct)) begin
        in_valid = 1'b1;
        in_data  = bytes[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      #1;
      check("in_ready", 32'({in_ready8, in_ready4}), 32'({2{!exp_valid || out_ready}}));
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      exp_valid = exp_valid && !out_ready;
      if (in_valid && (!exp_valid || out_ready || exp_q.size() == 0)) begin
        model_byte(bytes[idx], prod, bt);
        idx++;
        if (prod) begin
          exp_q.push_back(bt);
          exp_valid = 1'b1;
        end
      end
      cyc++;
    end
    check("run_timeout", 32'(cyc >= budget), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_out8", 32'({out_valid8, out_data8, sop8, eop8, chan8}), 32'd0);
      check("reset_out4", 32'({out_valid4, out_data4, sop4, eop4, chan4}), 32'd0);
    end
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("ready_after_reset", 32'({in_ready8, in_ready4}), 32'b11);
  endtask

  initial begin
    logic [7:0] q[$];
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    model_clear();
    do_reset();

    // basic packet at full rate
    q = '{8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33};
    run(q, 100, 100, 0);

    // channel select plus escaped data
    q = '{8'h7C, 8'h05, 8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D};
    run(q, 100, 100, 0);

    // single-beat packet and repeated markers
    q = '{8'h7A, 8'h7B, 8'h99, 8'h7A, 8'h7A, 8'h41};
    run(q, 100, 100, 0);

    // held beat under backpressure
    q = '{8'h7A, 8'h01, 8'h02, 8'h03, 8'h7B, 8'h04};
    run(q, 100, 100, 6);

    // escaped channel byte, 4-bit channel sees 4'hC
    q = '{8'h7C, 8'h7D, 8'h5C, 8'h41};
    run(q, 100, 100, 0);

    // reset mid-escape discards pending state
    q = '{8'h7A, 8'h7D};
    run(q, 100, 100, 0);
    do_reset();
    q = '{8'h42};
    run(q, 100, 100, 0);

    // randomized streams rich in framing characters
    for (int r = 0; r < 3; r++) begin
      q.delete();
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(99) < 35) q.push_back(8'(8'h7A + 8'($urandom_range(3))));
        else q.push_back(8'($urandom));
      end
      run(q, (r == 0) ? 100 : 70, (r == 2) ? 100 : 60, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
